gumnut_alu_ctrl: RTL and testbench
==================================

# gumnut_alu_ctrl

Sequencing controller between the Gumnut decode/execute stage and the 8-bit ALU. It accepts one ALU operation per valid/ready handshake, registers the operands, and drives the ALU. It holds the carry/zero condition-code registers and feeds carry back for add-with-carry and subtract-with-borrow. Shift/rotate operations run as repeated single-bit ALU steps, and the result is returned on a valid/ready response channel.

## Interface
- No parameters; datapath fixed at 8 bits, op code 4 bits, shift count 3 bits.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request (IDLE only)
- op_i  in  4  ALU op code (0000–1011 legal)
- rs_i  in  8  first operand
- op2_i  in  8  second operand
- count_i  in  3  shift/rotate amount
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- res_o  out  8  result
- err_o  out  1  illegal op code in this response
- cc_carry_o  out  1  carry flag register
- cc_zero_o  out  1  zero flag register
- alu_op_o  out  4  to ALU op select
- alu_rs_o / alu_op2_o  out  8  to ALU operands
- alu_count_o  out  3  to ALU count
- alu_carry_o  out  1  to ALU carry-in (= cc_carry_o)
- alu_res_i  in  8  from ALU result
- alu_carry_i  in  1  from ALU carry-out

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch op, rs, op2 and count. Load the step counter and go to EXEC.
- EXEC, ops 0000–0111:
  - Drive alu_* from the latched operands for one cycle.
  - Capture alu_res_i and alu_carry_i, then go to DONE.
- EXEC, ops 1000–1011 with count c≥1:
  - Each cycle drive alu_count_o=1 and alu_op2_o=latched op2.
  - alu_rs_o comes from the working register: the latched rs on the first step, the previous alu_res_i after that.
  - Decrement the counter each step. After step c go to DONE with the final result and carry.
- EXEC, shift with c=0: one cycle, no ALU result used. res=rs, carry flag unchanged.
- EXEC, op 1100–1111: one cycle, res=0x00, err_o=1, both flags unchanged.
- Flags:
  - cc_carry_o and cc_zero_o update on the EXEC→DONE edge.
  - zero = (final res == 0x00); the controller computes it, not the ALU.
- DONE:
  - rsp_valid_o=1; res_o and err_o are stable.
  - When rsp_ready_i=1, go to IDLE.
- Outputs outside EXEC: alu_op_o, alu_rs_o, alu_op2_o and alu_count_o are driven to 0.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, so req_ready_o=1.
  - rsp_valid_o=0, res_o=0x00, err_o=0, cc_carry_o=0, cc_zero_o=0, all alu_* outputs=0.
- Latency, with handshake in cycle 0:
  - Non-shift: EXEC in cycle 1, rsp_valid_o in cycle 2.
  - Shift with count c≥1: EXEC in cycles 1..c, rsp_valid_o in cycle c+1.
- Throughput: at most one request per 3 cycles. req_ready_o=0 throughout EXEC and DONE, including the cycle in which rsp_ready_i is accepted.
- Back-pressure: rsp_valid_o, res_o and err_o hold indefinitely while rsp_ready_i=0.
- Reset mid-EXEC or mid-DONE: the operation is discarded, flags clear, and no response is issued.
- req_valid_i outside IDLE is ignored; no request is buffered.

## Configuration
- ALU_CTRL_SHIFT_SEQ_EN defined: shifts use the multi-cycle single-bit stepping described above.
- Undefined: shifts take one EXEC cycle with alu_count_o=latched count, and the result is taken directly. Latency equals a non-shift op. Count 0 still returns rs with carry unchanged.

## Test plan
Bench ALU model implements 1000 as logical shift left, with carry = last bit shifted out.
- add 0x7F+0x01 → res 0x80, carry 0, zero 0; rsp_valid_o 2 cycles after handshake.
- Set carry via 0xFF+0x01 (res 0x00, carry 1, zero 1), then addc 0xFF+0x00 → alu_carry_o=1, res 0x00, carry 1, zero 1.
- With SEQ_EN: op 1000, rs 0x81, count 3 → three EXEC cycles with alu_count_o=1 → res 0x08, carry 0, rsp_valid_o in cycle 4. Without SEQ_EN: alu_count_o=3, same result, response in cycle 2.
- rsp_ready_i held 0 for 5 cycles → response held stable, req_ready_o=0, a new req_valid_i is ignored.
- Op 1101 → res 0x00, err_o=1, flags unchanged from the prior op.
- rst_i asserted in the 2nd EXEC cycle of a count-5 shift → all outputs at reset values immediately, no response after release.

Source files
------------

// File: rtl/gumnut_alu_ctrl.sv
// gumnut_alu_ctrl
// Sequencing controller between the Gumnut decode/execute stage and the
// 8-bit ALU. Accepts one op per req handshake, drives the ALU, holds the
// carry/zero condition codes and returns the result on a rsp handshake.
//
// Ports:
//   clk_i, rst_i (async, active high)
//   req_valid_i / req_ready_o, op_i[3:0], rs_i[7:0], op2_i[7:0], count_i[2:0]
//   rsp_valid_o / rsp_ready_i, res_o[7:0], err_o
//   cc_carry_o, cc_zero_o          condition-code registers
//   alu_op_o, alu_rs_o, alu_op2_o, alu_count_o, alu_carry_o  -> ALU
//   alu_res_i, alu_carry_i                                   <- ALU
//
// Config macro: ALU_CTRL_SHIFT_SEQ_EN
//   defined   - shifts (1000-1011) step the ALU one bit per EXEC cycle
//   undefined - shifts take one EXEC cycle with the full count
module gumnut_alu_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] op_i,
  input  logic [7:0] rs_i,
  input  logic [7:0] op2_i,
  input  logic [2:0] count_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] res_o,
  output logic       err_o,
  output logic       cc_carry_o,
  output logic       cc_zero_o,
  output logic [3:0] alu_op_o,
  output logic [7:0] alu_rs_o,
  output logic [7:0] alu_op2_o,
  output logic [2:0] alu_count_o,
  output logic       alu_carry_o,
  input  logic [7:0] alu_res_i,
  input  logic       alu_carry_i
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_op;
  logic [7:0] r_rs;    // working register: latched rs, then partial shift result
  logic [7:0] r_op2;
  logic [2:0] r_cnt;   // remaining shift steps
  logic [7:0] r_res;
  logic       r_err;
  logic       r_carry;
  logic       r_zero;

  logic       w_is_shift;
  logic       w_illegal;
  logic       w_last;  // this EXEC cycle is the final one
  logic [3:0] w_alu_op;
  logic [7:0] w_alu_rs;
  logic [7:0] w_alu_op2;
  logic [2:0] w_alu_count;

  assign w_is_shift = (r_op[3:2] == 2'b10);
  assign w_illegal  = (r_op[3:2] == 2'b11);

`ifdef ALU_CTRL_SHIFT_SEQ_EN
  // Keep stepping while more than one single-bit step remains.
  assign w_last = !(w_is_shift && (r_cnt > 3'd1));
`else
  assign w_last = 1'b1;
`endif

  always_comb begin
    w_next      = r_state;
    w_alu_op    = 4'd0;
    w_alu_rs    = 8'd0;
    w_alu_op2   = 8'd0;
    w_alu_count = 3'd0;
    case (r_state)
      S_IDLE: if (req_valid_i) w_next = S_EXEC;
      S_EXEC: begin
        w_alu_op    = r_op;
        w_alu_rs    = r_rs;
        w_alu_op2   = r_op2;
        w_alu_count = r_cnt;
`ifdef ALU_CTRL_SHIFT_SEQ_EN
        if (w_is_shift && (r_cnt != 3'd0)) w_alu_count = 3'd1;
`endif
        if (w_last) w_next = S_DONE;
      end
      S_DONE: if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_op    <= 4'd0;
      r_rs    <= 8'd0;
      r_op2   <= 8'd0;
      r_cnt   <= 3'd0;
      r_res   <= 8'd0;
      r_err   <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_op  <= op_i;
          r_rs  <= rs_i;
          r_op2 <= op2_i;
          r_cnt <= count_i;
        end
        S_EXEC: begin
          if (!w_last) begin
            r_rs  <= alu_res_i;
            r_cnt <= r_cnt - 3'd1;
          end else if (w_illegal) begin
            r_res <= 8'd0;
            r_err <= 1'b1;
          end else if (w_is_shift && (r_cnt == 3'd0)) begin
            // Zero-count shift passes rs through; carry is left alone.
            r_res  <= r_rs;
            r_err  <= 1'b0;
            r_zero <= (r_rs == 8'd0);
          end else begin
            r_res   <= alu_res_i;
            r_err   <= 1'b0;
            r_carry <= alu_carry_i;
            r_zero  <= (alu_res_i == 8'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_DONE);
  assign res_o       = r_res;
  assign err_o       = r_err;
  assign cc_carry_o  = r_carry;
  assign cc_zero_o   = r_zero;
  assign alu_op_o    = w_alu_op;
  assign alu_rs_o    = w_alu_rs;
  assign alu_op2_o   = w_alu_op2;
  assign alu_count_o = w_alu_count;
  assign alu_carry_o = r_carry;

endmodule

// File: tb/tb_gumnut_alu_ctrl.sv
module tb_gumnut_alu_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [3:0] op = 4'd0;
  logic [7:0] rs = 8'd0, op2 = 8'd0;
  logic [2:0] cnt = 3'd0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] res;
  logic       err, cc_c, cc_z;
  logic [3:0] a_op;
  logic [7:0] a_rs, a_op2, a_res;
  logic [2:0] a_cnt;
  logic       a_cin, a_cout;

  int tests = 0, fails = 0;

  // Model state: condition codes as the spec defines them.
  logic m_c = 1'b0, m_z = 1'b0;

  always #5 clk = ~clk;

  gumnut_alu_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .rs_i(rs), .op2_i(op2), .count_i(cnt),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .res_o(res), .err_o(err),
    .cc_carry_o(cc_c), .cc_zero_o(cc_z),
    .alu_op_o(a_op), .alu_rs_o(a_rs), .alu_op2_o(a_op2), .alu_count_o(a_cnt),
    .alu_carry_o(a_cin), .alu_res_i(a_res), .alu_carry_i(a_cout));

  // Behavioural 8-bit ALU: returns {carry, result}. Shifts move n bits,
  // carry = last bit shifted/rotated out; n=0 returns a with carry-in.
  function automatic logic [8:0] alu_f(input logic [3:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci, input int n);
    logic [8:0] t;
    logic [7:0] v;
    logic c;
    v = a; c = ci;
    case (o)
      4'd0: t = {1'b0, a} + {1'b0, b};
      4'd1: t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      4'd2: t = {1'b0, a} - {1'b0, b};
      4'd3: t = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      4'd4: t = {1'b0, a & b};
      4'd5: t = {1'b0, a | b};
      4'd6: t = {1'b0, a ^ b};
      4'd7: t = {1'b0, a & ~b};
      4'd8, 4'd9, 4'd10, 4'd11: begin
        for (int i = 0; i < n; i++) begin
          case (o)
            4'd8:    begin c = v[7]; v = {v[6:0], 1'b0}; end
            4'd9:    begin c = v[0]; v = {1'b0, v[7:1]}; end
            4'd10:   begin c = v[7]; v = {v[6:0], v[7]}; end
            default: begin c = v[0]; v = {v[0], v[7:1]}; end
          endcase
        end
        t = {c, v};
      end
      default: t = 9'd0;
    endcase
    return t;
  endfunction

  always_comb {a_cout, a_res} = alu_f(a_op, a_rs, a_op2, a_cin, int'(a_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ready"}, {31'd0, req_ready}, 1);
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 0);
    chk({tag, " res/err"}, {23'd0, res, err}, 0);
    chk({tag, " flags"}, {30'd0, cc_c, cc_z}, 0);
    chk({tag, " alu outs"}, {a_op, a_rs, a_op2, a_cnt, a_cin}, 0);
  endtask

  // One transaction; expected values come from the spec rules.
  task automatic run_op(input logic [3:0] o, input logic [7:0] r, input logic [7:0] b,
                        input logic [2:0] c, input int stall);
    logic [7:0] e_res;
    logic e_err, e_c, e_z;
    logic [8:0] t;
    int e_lat, n;
    bit shift;
    shift = (o[3:2] == 2'b10);
    if (o[3:2] == 2'b11) begin
      e_res = 8'd0; e_err = 1'b1; e_c = m_c; e_z = m_z;
    end else if (shift && c == 3'd0) begin
      e_res = r; e_err = 1'b0; e_c = m_c; e_z = (r == 8'd0);
    end else begin
      t = alu_f(o, r, b, m_c, int'(c));
      e_res = t[7:0]; e_err = 1'b0; e_c = t[8]; e_z = (t[7:0] == 8'd0);
    end
`ifdef ALU_CTRL_SHIFT_SEQ_EN
    e_lat = (shift && c != 3'd0) ? int'(c) + 1 : 2;
`else
    e_lat = 2;
`endif
    @(negedge clk);
    chk("ready before req", {31'd0, req_ready}, 1);
    op = o; rs = r; op2 = b; cnt = c; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    op = ~o; rs = ~r;  // scramble inputs; the DUT must use latched copies
    n = 1;
    chk("alu carry-in", {31'd0, a_cin}, {31'd0, m_c});
    while (!rsp_valid && n < 20) begin
      chk("ready in exec", {31'd0, req_ready}, 0);
      if (shift && c != 3'd0) begin
`ifdef ALU_CTRL_SHIFT_SEQ_EN
        chk("alu_count step", {29'd0, a_cnt}, 1);
`else
        chk("alu_count full", {29'd0, a_cnt}, {29'd0, c});
`endif
      end
      @(negedge clk);
      n++;
    end
    chk("latency", n, e_lat);
    chk("res", {24'd0, res}, {24'd0, e_res});
    chk("err", {31'd0, err}, {31'd0, e_err});
    chk("carry", {31'd0, cc_c}, {31'd0, e_c});
    chk("zero", {31'd0, cc_z}, {31'd0, e_z});
    m_c = e_c; m_z = e_z;
    for (int i = 0; i < stall; i++) begin
      // A request during DONE must be ignored.
      req_valid = (i < stall - 1);
      op = 4'd0; rs = 8'h55; op2 = 8'h11;
      @(negedge clk);
      chk("stall hold", {22'd0, rsp_valid, req_ready, res}, {22'd0, 2'b10, e_res});
      chk("stall err", {31'd0, err}, {31'd0, e_err});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp retired", {30'd0, rsp_valid, req_ready}, 1);
  endtask

  initial begin
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd0, 8'h7F, 8'h01, 3'd0, 0);   // 0x80, c0 z0
    run_op(4'd0, 8'hFF, 8'h01, 3'd0, 0);   // 0x00, c1 z1
    run_op(4'd1, 8'hFF, 8'h00, 3'd0, 0);   // addc -> 0x00, c1 z1
    run_op(4'd8, 8'h81, 8'h00, 3'd3, 0);   // shl 3 -> 0x08, c0
    run_op(4'd2, 8'h10, 8'h20, 3'd0, 5);   // back-pressure with ignored req
    run_op(4'd13, 8'h12, 8'h34, 3'd0, 0);  // illegal op
    run_op(4'd9, 8'h00, 8'h00, 3'd0, 0);   // count-0 shift, zero rs

    // Reset during the second EXEC cycle of a count-5 shift.
    @(negedge clk);
    op = 4'd8; rs = 8'h3C; op2 = 8'h00; cnt = 3'd5; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outs("mid-exec reset");
    m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("no rsp after reset", {30'd0, rsp_valid, req_ready}, 1);
    end

    // Randomised ops against the model.
    for (int k = 0; k < 40; k++)
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
